pipelined_add_sub: RTL and testbench



---
 rtl/pipelined_add_sub_pkg.sv | 9 +
 rtl/pipelined_add_sub_if.sv | 31 +++
 rtl/pipelined_add_sub_add_segment.sv | 30 +++
 rtl/pipelined_add_sub.sv | 112 +++++++++++
 tb/tb_pipelined_add_sub.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   OP_ADD / OP_SUB        : encodings of the sna mode input
package pipelined_add_sub_pkg;
  localparam int   DEF_WIDTH  = 32;
  localparam int   DEF_STAGES = 4;
  localparam logic OP_ADD     = 1'b0;
  localparam logic OP_SUB     = 1'b1;
endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for pipelined_add_sub.
//   in_valid/in_ready   : operation transfer into the block
//   a, b, sna           : operands and mode (1 = a-b, 0 = a+b)
//   out_valid/out_ready : result transfer out of the block
//   y, co, ovf          : result, carry out of MSB, signed overflow
// master = operand source / result consumer, slave = the adder.
interface pipelined_add_sub_if
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sna;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, sna, out_ready,
    input  in_ready, out_valid, y, co, ovf
  );
  modport slave (
    input  in_valid, a, b, sna, out_ready,
    output in_ready, out_valid, y, co, ovf
  );
endinterface

// File: rtl/pipelined_add_sub_add_segment.sv
// add_segment: W-bit ripple-carry adder built from full-adder cells.
//   a, b     : operand slices (b already inverted for subtract)
//   ci       : carry in from the previous segment
//   s        : sum slice
//   co       : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB (overflow detect in top segment)
module add_segment
  import pipelined_add_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor split into STAGES ripple
// segments, one register level per segment, valid/ready handshake.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipelined_add_sub_if slave (operands in, results out)
// Segment j sees its operand slice after j skew registers and its result
// slice travels through STAGES-j deskew registers, so every bit of one
// operation lands in y on the same edge. The whole pipe freezes while a
// completed result is waiting on out_ready.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic                clk,
  input logic                rst,
  pipelined_add_sub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic              en;
  logic [WIDTH-1:0]  b_eff;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   c_pipe;
  logic [STAGES:1]   c_q;
  logic [STAGES-1:0] seg_co;
  logic              c_msb_top;
  logic              ovf_q;
  logic [WIDTH-1:0]  y_dsk;

  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  // Subtract = a + ~b + 1; the +1 enters as carry into segment 0.
  assign b_eff    = (bus.sna == OP_ADD) ? bus.b : ~bus.b;
  assign vld_pipe = {vld_q, bus.in_valid && en};
  assign c_pipe   = {c_q, bus.sna == OP_SUB};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= vld_pipe[STAGES-1:0];
      c_q   <= seg_co;
      ovf_q <= c_msb_top ^ seg_co[STAGES-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    localparam int RD = STAGES - j;
    logic [SW-1:0] seg_a, seg_b, seg_s;
    logic [SW-1:0] r_dl [RD];

    if (j == 0) begin : g_in
      assign seg_a = bus.a[0 +: SW];
      assign seg_b = b_eff[0 +: SW];
    end else begin : g_skew
      logic [SW-1:0] a_dl [j];
      logic [SW-1:0] b_dl [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < j; i++) begin
            a_dl[i] <= '0;
            b_dl[i] <= '0;
          end
        end else if (en) begin
          a_dl[0] <= bus.a[j*SW +: SW];
          b_dl[0] <= b_eff[j*SW +: SW];
          for (int i = 1; i < j; i++) begin
            a_dl[i] <= a_dl[i-1];
            b_dl[i] <= b_dl[i-1];
          end
        end
      end
      assign seg_a = a_dl[j-1];
      assign seg_b = b_dl[j-1];
    end

    if (j == STAGES - 1) begin : g_top
      add_segment #(.W(SW)) u_seg (
        .a(seg_a), .b(seg_b), .ci(c_pipe[j]),
        .s(seg_s), .co(seg_co[j]), .c_msb_in(c_msb_top)
      );
    end else begin : g_mid
      logic c_msb_unused;
      add_segment #(.W(SW)) u_seg (
        .a(seg_a), .b(seg_b), .ci(c_pipe[j]),
        .s(seg_s), .co(seg_co[j]), .c_msb_in(c_msb_unused)
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < RD; i++) r_dl[i] <= '0;
      end else if (en) begin
        r_dl[0] <= seg_s;
        for (int i = 1; i < RD; i++) r_dl[i] <= r_dl[i-1];
      end
    end

    assign y_dsk[j*SW +: SW] = r_dl[RD-1];
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.y         = y_dsk;
  assign bus.co        = c_pipe[STAGES];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three instances (STAGES 4, 1, 32) share one
// operand stream; each has its own transfer-driven scoreboard.
module tb_pipelined_add_sub;
  import pipelined_add_sub_pkg::*;

  localparam int W  = 32;
  localparam int ND = 3;

  typedef struct packed {
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sna;
    res_t         r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid, sna, out_ready;
  logic [W-1:0]  a, b;
  logic [ND-1:0] ir, ov;
  res_t          got [ND];

  int   checks = 0;
  int   errors = 0;
  res_t sb [ND][$];
  int   n_in  [ND];
  int   n_out [ND];

  pipelined_add_sub_if #(.WIDTH(W)) i4 ();
  pipelined_add_sub_if #(.WIDTH(W)) i1 ();
  pipelined_add_sub_if #(.WIDTH(W)) i32 ();

  assign i4.in_valid  = in_valid;  assign i4.a  = a; assign i4.b  = b;
  assign i4.sna       = sna;       assign i4.out_ready  = out_ready;
  assign i1.in_valid  = in_valid;  assign i1.a  = a; assign i1.b  = b;
  assign i1.sna       = sna;       assign i1.out_ready  = out_ready;
  assign i32.in_valid = in_valid;  assign i32.a = a; assign i32.b = b;
  assign i32.sna      = sna;       assign i32.out_ready = out_ready;

  assign ir     = {i32.in_ready, i1.in_ready, i4.in_ready};
  assign ov     = {i32.out_valid, i1.out_valid, i4.out_valid};
  assign got[0] = {i4.y, i4.co, i4.ovf};
  assign got[1] = {i1.y, i1.co, i1.ovf};
  assign got[2] = {i32.y, i32.co, i32.ovf};

  pipelined_add_sub #(.WIDTH(W), .STAGES(4))  u_s4  (.clk(clk), .rst(rst), .bus(i4.slave));
  pipelined_add_sub #(.WIDTH(W), .STAGES(1))  u_s1  (.clk(clk), .rst(rst), .bus(i1.slave));
  pipelined_add_sub #(.WIDTH(W), .STAGES(32)) u_s32 (.clk(clk), .rst(rst), .bus(i32.slave));

  function automatic int lat_of(int d);
    if (d == 0) return 4;
    if (d == 1) return 1;
    return 32;
  endfunction

  // Reference: plain 33-bit add; overflow from operand/result signs.
  function automatic res_t model(logic [W-1:0] oa, logic [W-1:0] ob, logic os);
    logic [W-1:0] bb;
    logic [W:0]   s;
    res_t         r;
    bb    = (os == OP_SUB) ? ~ob : ob;
    s     = {1'b0, oa} + {1'b0, bb} + {{W{1'b0}}, os};
    r.y   = s[W-1:0];
    r.co  = s[W];
    if (os == OP_SUB) r.ovf = (oa[W-1] != ob[W-1]) && (r.y[W-1] != oa[W-1]);
    else              r.ovf = (oa[W-1] == ob[W-1]) && (r.y[W-1] != oa[W-1]);
    return r;
  endfunction

  // Scoreboard: push on each instance's own transfer in, pop on transfer out.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      for (int d = 0; d < ND; d++) sb[d].delete();
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (in_valid && ir[d]) begin
          sb[d].push_back(model(a, b, sna));
          n_in[d]++;
        end
        if (ov[d] && out_ready) begin
          n_out[d]++;
          checks++;
          if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL sb_extra dut%0d got %h required no output", d, got[d]);
          end else begin
            e = sb[d].pop_front();
            if (got[d] !== e) begin
              errors++;
              $display("FAIL sb_result dut%0d got %h required %h", d, got[d], e);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if ({ov[d], got[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d got ov=%b res=%h required 0", d, ov[d], got[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 111", ir);
    end
  endtask

  // One operation then idle; each instance must present it exactly at its latency.
  task automatic run_single(input vec_t t, input string nm, input logic chk_val);
    a = t.a; b = t.b; sna = t.sna; in_valid = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (ov[d] !== (c == lat_of(d))) begin
          errors++;
          $display("FAIL %s_valid dut%0d cyc%0d got %b required %b", nm, d, c, ov[d], c == lat_of(d));
        end
        if (chk_val && c == lat_of(d)) begin
          checks++;
          if (got[d] !== t.r) begin
            errors++;
            $display("FAIL %s_value dut%0d got %h required %h", nm, d, got[d], t.r);
          end
        end
      end
    end
  endtask

  task automatic test_directed();
    vec_t v [6];
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, '{32'h0000_0000, 1'b1, 1'b0}};
    v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, '{32'h8000_0000, 1'b0, 1'b1}};
    v[2] = '{32'h8000_0000, 32'h0000_0001, OP_SUB, '{32'h7FFF_FFFF, 1'b1, 1'b1}};
    v[3] = '{32'h0000_0005, 32'h0000_0007, OP_SUB, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
    v[4] = '{32'h0000_0007, 32'h0000_0005, OP_SUB, '{32'h0000_0002, 1'b1, 1'b0}};
    v[5] = '{32'h8000_0000, 32'h8000_0000, OP_ADD, '{32'h0000_0000, 1'b1, 1'b1}};
    for (int i = 0; i < 6; i++) run_single(v[i], $sformatf("directed%0d", i), 1'b1);
  endtask

  task automatic test_back_to_back();
    int o0 [ND];
    for (int d = 0; d < ND; d++) o0[d] = n_out[d];
    out_ready = 1'b1;
    for (int c = 0; c < 42; c++) begin
      if (c < 8) begin
        a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (ov[d] !== (c + 1 >= lat_of(d) && c + 1 < lat_of(d) + 8)) begin
          errors++;
          $display("FAIL b2b_valid dut%0d cyc%0d got %b", d, c + 1, ov[d]);
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (n_out[d] - o0[d] != 8) begin
        errors++;
        $display("FAIL b2b_count dut%0d got %0d required 8", d, n_out[d] - o0[d]);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] oa [10];
    logic [W-1:0] ob [10];
    logic         os [10];
    res_t         hold;
    logic         acc;
    int           k, i0, o0;
    for (int i = 0; i < 10; i++) begin
      oa[i] = $urandom; ob[i] = $urandom; os[i] = 1'($urandom_range(0, 1));
    end
    k = 0; i0 = n_in[0]; o0 = n_out[0]; hold = '0;
    for (int c = 0; c < 60; c++) begin
      out_ready = !(c >= 6 && c <= 8);
      if (k < 10) begin
        a = oa[k]; b = ob[k]; sna = os[k]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && ir[0];
      if (c == 6) hold = got[0];
      if (c >= 6 && c <= 8) begin
        checks++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
          errors++;
          $display("FAIL stall_ready cyc%0d got in_ready=%b out_valid=%b required 0/1", c, ir[0], ov[0]);
        end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (got[0] !== hold) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got %h required %h", c, got[0], hold);
        end
      end
      @(posedge clk); #1;
      if (acc) k++;
    end
    out_ready = 1'b1;
    checks++;
    if (n_in[0] - i0 != 10 || n_out[0] - o0 != 10) begin
      errors++;
      $display("FAIL stall_count got in=%0d out=%0d required 10/10", n_in[0] - i0, n_out[0] - o0);
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL stall_drain dut%0d got %0d pending required 0", d, sb[d].size());
      end
    end
  endtask

  task automatic test_reset_inflight();
    vec_t t;
    for (int c = 0; c < 3; c++) begin
      a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || got[d].y !== '0) begin
        errors++;
        $display("FAIL rst_flush dut%0d got ov=%b y=%h required 0/0", d, ov[d], got[d].y);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ir !== 3'b111) begin
      errors++;
      $display("FAIL rst_in_ready got %b required 111", ir);
    end
    t.a = $urandom; t.b = $urandom; t.sna = OP_SUB;
    t.r = model(t.a, t.b, t.sna);
    run_single(t, "post_rst", 1'b1);
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; sna = OP_ADD; out_ready = 1'b1;
    for (int d = 0; d < ND; d++) begin n_in[d] = 0; n_out[d] = 0; end
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
